bus_slave_rx: RTL and testbench
===============================

BUS_SLAVE_RX -- requirements
Module: bus_slave_rx

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in 2-bit words; SHALL be a power of two and at least 4.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req  input  1  bus request from the upstream bus master's req_out.
REQ-005 bus_data  input  2  bus data from the upstream master's data_out; may be Z outside valid cycles.
REQ-006 rd_en  input  1  local consumer pop strobe.
REQ-007 ack  output  1  registered bus grant to the upstream master.
REQ-008 rd_data  output  2  FIFO head word, show-ahead.
REQ-009 rd_valid  output  1  high when FIFO non-empty.
REQ-010 full / empty  output  1 each  FIFO status.
REQ-011 count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-012 xfer_cnt  output  8  total words captured since reset, wraps 255->0.

Function
REQ-013 SHALL implement FSM states IDLE (ack=0), GRANT (ack=1) and DRAIN (ack=0, waiting on in-flight words).
REQ-014 Definitions: ack_q is the registered ack; vld_q is ack_q delayed one cycle; inflight = ack_q + vld_q.
REQ-015 IDLE->GRANT SHALL occur when req=1 and count+inflight < DEPTH.
REQ-016 GRANT->DRAIN SHALL occur when req=0 or count+inflight+1 >= DEPTH; otherwise the FSM stays in GRANT.
REQ-017 DRAIN->IDLE SHALL occur when ack_q=0 and vld_q=0; DRAIN->GRANT SHALL occur directly if the REQ-015 condition holds.
REQ-018 SHALL capture bus_data into the FIFO at every rising edge where vld_q=1, and SHALL never sample bus_data otherwise.
REQ-019 Capture timing: word on bus during cycle c+1 after ack rose at edge c SHALL be pushed at edge c+2.
REQ-020 Latency: req sampled high at edge 0 with FIFO empty -> ack=1 after edge 1 -> rd_valid=1 after edge 3.
REQ-021 Room check SHALL ignore same-cycle pops (conservative), so a push never finds the FIFO full.
REQ-022 A push while full SHALL be dropped, with count and xfer_cnt unchanged; this is a design-bug condition.
REQ-023 rd_en while empty SHALL be ignored, with no change to pointers or count.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and update both pointers.
REQ-025 Pointers SHALL wrap modulo DEPTH; full=(count==DEPTH), empty=(count==0).
REQ-026 xfer_cnt SHALL increment by 1 per accepted push.
REQ-027 req deasserting mid-burst SHALL NOT discard in-flight words; words with vld_q=1 are still captured.

Reset
REQ-028 While reset=1: ack=0, state=IDLE, ack_q=vld_q=0, count=0, pointers=0, xfer_cnt=0, empty=1, full=0, rd_valid=0, rd_data=0.
REQ-029 Reset mid-burst SHALL discard all stored and in-flight words; the first grant after release follows REQ-015 timing.

Structure
REQ-030 A shared package bus_pkg SHALL hold the FSM state enumeration (IDLE, GRANT, DRAIN), the bus data width constant (2) and the DEPTH default.
REQ-031 The FIFO storage, pointers and count SHALL live in one sub-module, bus_rx_fifo.
REQ-032 FSM, ack/vld_q pipeline and xfer_cnt SHALL live in the top level.

Verification
REQ-033 Single word: req=1 for one grant, bus_data=2'b10 on the valid cycle -> rd_valid=1 after edge 3, rd_data=2'b10, count=1, xfer_cnt=1.
REQ-034 Burst: req held high, bus sequence 1,2,3,0 with DEPTH=4 and no pops -> ack drops before overflow, FIFO holds 1,2,3,0, full=1, no word lost.
REQ-035 Backpressure: FIFO full, rd_en pulsed once -> count=3, ack re-asserts per REQ-015, next bus word lands in the freed slot.
REQ-036 Simultaneous push/pop at count=2 -> count stays 2, rd_data advances to the next word.
REQ-037 Reset asserted with 2 words stored and vld_q=1 -> count=0, ack=0, xfer_cnt=0 immediately; the in-flight word is not stored.
REQ-038 Wrap: 256 captured words with continuous pops -> xfer_cnt returns to 0, pointers wrap, data order preserved.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus receive slave: state encoding, bus width and default FIFO depth.
package bus_pkg;
  localparam int BUS_W     = 2;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/bus_rx_fifo.sv
// Show-ahead FIFO for received bus words; holds the storage, pointers and occupancy count.
module bus_rx_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [BUS_W-1:0]         wr_data,
  input  logic                     pop,
  output logic                     accepted,
  output logic [BUS_W-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BUS_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign accepted = push & ~full;
  assign pop_ok   = pop & ~empty;
  // Head word is forced to zero when empty so the output is clean out of reset.
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)   rd_ptr <= rd_ptr + AW'(1);
      case ({accepted, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/bus_slave_rx.sv
// Bus receive slave: grants the upstream master only when every granted word is sure to fit.
// state | meaning
// IDLE  | no grant, nothing in flight
// GRANT | ack issued next cycle, words being requested
// DRAIN | grant withdrawn, waiting for in-flight words to land
module bus_slave_rx
  import bus_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic [BUS_W-1:0]       bus_data,
  input  logic                   rd_en,
  output logic                   ack,
  output logic [BUS_W-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             xfer_cnt
);
  localparam int SW = $clog2(DEPTH) + 2;

  state_t        state;
  state_t        state_nxt;
  logic          ack_q;
  logic          vld_q;
  logic          accepted;
  logic [SW-1:0] occ;
  logic          room_idle;
  logic          room_grant;

  // Committed occupancy: stored words plus words already granted; pops are not credited.
  assign occ        = SW'(count) + SW'(ack_q) + SW'(vld_q);
  assign room_idle  = (occ < SW'(DEPTH));
  assign room_grant = ((occ + SW'(1)) < SW'(DEPTH));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req && room_idle) state_nxt = GRANT;
      GRANT:   if (!req || !room_grant) state_nxt = DRAIN;
      DRAIN: begin
        if (req && room_idle)       state_nxt = GRANT;
        else if (!ack_q && !vld_q)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ack_q    <= 1'b0;
      vld_q    <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= (state == GRANT);
      vld_q <= ack_q;
      if (accepted) xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

  assign ack      = ack_q;
  assign rd_valid = ~empty;

  bus_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (vld_q),
    .wr_data  (bus_data),
    .pop      (rd_en),
    .accepted (accepted),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );
endmodule

// File: tb/tb_bus_slave_rx.sv
// Directed bench for bus_slave_rx: a simple master answers each ack with the next queued word.
module tb_bus_slave_rx;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [1:0] bus_data;
  logic       rd_en = 1'b0;
  logic       ack;
  logic [1:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic [7:0] xfer_cnt;

  int         n_tests = 0;
  int         n_fail = 0;
  logic       ack_s = 1'b0;
  int         ack_cycles = 0;
  logic [1:0] tx_q [$];
  logic [1:0] exp_w [256];
  int         rx_idx = 0;
  logic       wrap_on = 1'b0;

  bus_slave_rx #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .bus_data (bus_data),
    .rd_en    (rd_en),
    .ack      (ack),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ack_s = ack;
    if (ack) ack_cycles++;
  end

  // Master: a word is driven for the cycle after ack was seen high, Z otherwise.
  initial bus_data = 'z;
  always @(posedge clk) begin
    #1;
    if (ack_s) begin
      if (tx_q.size() > 0) bus_data = tx_q.pop_front();
      else                 bus_data = 2'b11;
    end else begin
      bus_data = 'z;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (wrap_on && rd_valid) begin
      if (rx_idx < 256) chk($sformatf("wrap_data[%0d]", rx_idx), 32'(rd_data), 32'(exp_w[rx_idx]));
      else              chk("wrap_extra_word", 32'(rx_idx), 32'd255);
      rx_idx++;
    end
  endtask

  task automatic pop_chk(input logic [1:0] exp);
    chk("pop_head", 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // Single word with latency checks
    tx_q.push_back(2'b10);
    req = 1'b1;
    step();
    chk("single_ack_e0", 32'(ack), 32'd0);
    req = 1'b0;
    step();
    chk("single_ack_e1", 32'(ack), 32'd1);
    step();
    chk("single_ack_e2", 32'(ack), 32'd0);
    chk("single_valid_e2", 32'(rd_valid), 32'd0);
    step();
    chk("single_valid_e3", 32'(rd_valid), 32'd1);
    chk("single_data", 32'(rd_data), 32'd2);
    chk("single_count", 32'(count), 32'd1);
    chk("single_xfer", 32'(xfer_cnt), 32'd1);
    pop_chk(2'b10);
    chk("single_empty", 32'(empty), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pop_empty_count", 32'(count), 32'd0);
    chk("pop_empty_data", 32'(rd_data), 32'd0);
    step(); step();

    // Burst to full with no pops
    tx_q = '{2'd1, 2'd2, 2'd3, 2'd0};
    ack_cycles = 0;
    req = 1'b1;
    repeat (12) step();
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_count", 32'(count), 32'd4);
    chk("burst_ack_low", 32'(ack), 32'd0);
    chk("burst_ack_cycles", 32'(ack_cycles), 32'd4);
    chk("burst_xfer", 32'(xfer_cnt), 32'd5);
    chk("burst_head", 32'(rd_data), 32'd1);
    chk("burst_tx_left", 32'(tx_q.size()), 32'd0);

    // Backpressure: one pop frees exactly one slot
    tx_q.push_back(2'b01);
    ack_cycles = 0;
    pop_chk(2'd1);
    chk("bp_count", 32'(count), 32'd3);
    chk("bp_head", 32'(rd_data), 32'd2);
    repeat (8) step();
    chk("bp_refull", 32'(full), 32'd1);
    chk("bp_ack_cycles", 32'(ack_cycles), 32'd1);
    chk("bp_xfer", 32'(xfer_cnt), 32'd6);
    req = 1'b0;
    pop_chk(2'd2);
    pop_chk(2'd3);
    chk("pp_pre_count", 32'(count), 32'd2);

    // Simultaneous push and pop at count 2
    tx_q.push_back(2'b11);
    req = 1'b1;
    step();
    req = 1'b0;
    step(); step();
    chk("pp_pre_head", 32'(rd_data), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pp_count", 32'(count), 32'd2);
    chk("pp_head", 32'(rd_data), 32'd1);
    chk("pp_xfer", 32'(xfer_cnt), 32'd7);
    step();
    pop_chk(2'd1);
    pop_chk(2'd3);
    chk("pp_empty", 32'(empty), 32'd1);
    step(); step();

    // Reset mid-burst with two words stored and one in flight
    tx_q = '{2'd1, 2'd2, 2'd3, 2'd0};
    req = 1'b1;
    repeat (5) step();
    chk("mid_count", 32'(count), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_xfer", 32'(xfer_cnt), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    req = 1'b0;
    step(); step();
    reset = 1'b0;
    tx_q.delete();
    repeat (4) step();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_xfer", 32'(xfer_cnt), 32'd0);

    // Wrap: 256 single-word grants with continuous pops
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      exp_w[i] = b[1:0] ^ b[3:2] ^ b[5:4] ^ b[7:6];
    end
    wrap_on = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tx_q.push_back(exp_w[i]);
      req = 1'b1;
      step();
      if (i == 0) chk("regrant_ack_e0", 32'(ack), 32'd0);
      req = 1'b0;
      step();
      if (i == 0) chk("regrant_ack_e1", 32'(ack), 32'd1);
      step(); step(); step();
      if (i == 254) chk("wrap_xfer_255", 32'(xfer_cnt), 32'd255);
    end
    step(); step();
    rd_en = 1'b0;
    wrap_on = 1'b0;
    chk("wrap_rx_count", 32'(rx_idx), 32'd256);
    chk("wrap_xfer", 32'(xfer_cnt), 32'd0);
    chk("wrap_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
